// File: rtl/instr_fetch.sv
// instr_fetch: per-core opcode/immediate fetcher driving one memory read port, valid/ready to the control unit, PC with jump redirect and ENDOP halt
module instr_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [DATA_WIDTH-1:0] OP_LDACI = 8'd0,
  parameter logic [DATA_WIDTH-1:0] OP_STACI = 8'd13,
  parameter logic [DATA_WIDTH-1:0] OP_JPNZ = 8'd27,
  parameter logic [DATA_WIDTH-1:0] OP_ENDOP = 8'd28,
  parameter logic [DATA_WIDTH-1:0] OP_MAX = 8'd47
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] r_instr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  has_operand,
  output logic                  illegal,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);
  typedef enum logic [2:0] {IDLE, REQ_OP, DAT_OP, REQ_IMM, DAT_IMM, VALID, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, r_addr_q, r_addr_d;
  logic [DATA_WIDTH-1:0] opcode_q, opcode_d, operand_q, operand_d;
  logic valid_q, valid_d, has_q, has_d, illegal_q, illegal_d, halted_q, halted_d;
  logic is_imm;
  assign is_imm = (r_instr == OP_LDACI) | (r_instr == OP_STACI) | (r_instr == OP_JPNZ);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    r_addr_d = r_addr_q;
    opcode_d = opcode_q;
    operand_d = operand_q;
    valid_d = valid_q;
    has_d = has_q;
    illegal_d = illegal_q;
    halted_d = halted_q;
    case (state_q)
      IDLE, HALT: if (start) begin
        pc_d = START_ADDR;
        r_addr_d = START_ADDR;
        halted_d = 1'b0;
        state_d = REQ_OP;
      end
      REQ_OP: state_d = mem_busy ? REQ_OP : DAT_OP;
      DAT_OP: begin
        opcode_d = r_instr;
        operand_d = '0;
        has_d = is_imm;
        illegal_d = r_instr > OP_MAX;
        r_addr_d = is_imm ? pc_q + ADDR_WIDTH'(1) : r_addr_q;
        valid_d = !is_imm;
        state_d = is_imm ? REQ_IMM : VALID;
      end
      REQ_IMM: state_d = mem_busy ? REQ_IMM : DAT_IMM;
      DAT_IMM: begin
        operand_d = r_instr;
        valid_d = 1'b1;
        state_d = VALID;
      end
      VALID: if (instr_ready) begin
        valid_d = 1'b0;
        if (opcode_q == OP_ENDOP) begin
          halted_d = 1'b1;
          state_d = HALT;
        end else begin
          pc_d = jump_en ? jump_addr : pc_q + (has_q ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
          r_addr_d = pc_d;
          state_d = REQ_OP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= START_ADDR;
      r_addr_q <= START_ADDR;
      opcode_q <= '0;
      operand_q <= '0;
      valid_q <= 1'b0;
      has_q <= 1'b0;
      illegal_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      r_addr_q <= r_addr_d;
      opcode_q <= opcode_d;
      operand_q <= operand_d;
      valid_q <= valid_d;
      has_q <= has_d;
      illegal_q <= illegal_d;
      halted_q <= halted_d;
    end
  end
  assign r_addr = r_addr_q;
  assign pc = pc_q;
  assign opcode = opcode_q;
  assign operand = operand_q;
  assign instr_valid = valid_q;
  assign has_operand = has_q;
  assign illegal = illegal_q;
  assign halted = halted_q;
endmodule
